// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: operand buffer and diagonal-skew feeder for an
// ARRAY_SIZE x ARRAY_SIZE systolic array.
// Optional feature macro: SYSCTL_RUNCNT_EN adds a saturating run_count output.
module systolic_feed_ctrl #(
  parameter int ARRAY_SIZE   = 4,
  parameter int DATA_WIDTH   = 4,
  parameter int DRAIN_CYCLES = 2 * ARRAY_SIZE
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic                               wr_sel,
  input  logic [$clog2(ARRAY_SIZE)-1:0]      wr_row,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   wr_data,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               arr_clear,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   in_left,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   in_top
`ifdef SYSCTL_RUNCNT_EN
  ,
  output logic [15:0]                        run_count
`endif
);

  localparam int unsigned N          = ARRAY_SIZE;
  localparam int unsigned DW         = DATA_WIDTH;
  localparam int          ROW_W      = $clog2(ARRAY_SIZE);
  localparam int          FEED_STEPS = 2 * ARRAY_SIZE - 1;
  localparam int          CNT_MAX    = (FEED_STEPS > DRAIN_CYCLES) ? FEED_STEPS : DRAIN_CYCLES;
  localparam int          CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_STEPS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [N*DW-1:0]   a_buf [N];
  logic [N*DW-1:0]   b_buf [N];

  logic              busy_nxt, done_nxt, clear_nxt;
  logic [N*DW-1:0]   left_nxt, top_nxt;
  int unsigned       k;
  logic [ROW_W-1:0]  idx;

  // Operand buffers: host writes accepted only while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < N; r++) begin
        a_buf[r] <= '0;
        b_buf[r] <= '0;
      end
    end else if (wr_en && state == S_IDLE) begin
      if (wr_sel) b_buf[wr_row] <= wr_data;
      else        a_buf[wr_row] <= wr_data;
    end
  end

  // State and shared step/drain counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CLEAR;
          cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        state_nxt = S_FEED;
        cnt_nxt   = '0;
      end
      S_FEED: begin
        if (cnt == FEED_LAST) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the upcoming state/step.
  always_comb begin
    busy_nxt  = (state_nxt != S_IDLE);
    clear_nxt = (state_nxt == S_CLEAR);
    done_nxt  = (state_nxt == S_DONE);
    left_nxt  = '0;
    top_nxt   = '0;
    k         = 32'(cnt_nxt);
    idx       = '0;
    if (state_nxt == S_FEED) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (k >= i && (k - i) < N) begin
          idx = ROW_W'(k - i);
          left_nxt[i*DW +: DW] = a_buf[i][idx*DW +: DW];
          top_nxt[i*DW +: DW]  = b_buf[idx][i*DW +: DW];
        end
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      arr_clear <= 1'b0;
      in_left   <= '0;
      in_top    <= '0;
    end else begin
      busy      <= busy_nxt;
      done      <= done_nxt;
      arr_clear <= clear_nxt;
      in_left   <= left_nxt;
      in_top    <= top_nxt;
    end
  end

`ifdef SYSCTL_RUNCNT_EN
  // Completed-run counter, saturating; moves together with the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_count <= '0;
    end else if (done_nxt && run_count != 16'hFFFF) begin
      run_count <= run_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed testbench for systolic_feed_ctrl (N=4, DW=4, DRAIN=8).
module tb_systolic_feed_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic        wr_sel;
  logic [1:0]  wr_row;
  logic [15:0] wr_data;
  logic        start;
  logic        busy;
  logic        done;
  logic        arr_clear;
  logic [15:0] in_left;
  logic [15:0] in_top;
`ifdef SYSCTL_RUNCNT_EN
  logic [15:0] run_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_l [7];
  logic [15:0] exp_t [7];

  systolic_feed_ctrl #(
    .ARRAY_SIZE  (4),
    .DATA_WIDTH  (4),
    .DRAIN_CYCLES(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_row   (wr_row),
    .wr_data  (wr_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .arr_clear(arr_clear),
    .in_left  (in_left),
    .in_top   (in_top)
`ifdef SYSCTL_RUNCNT_EN
    ,
    .run_count(run_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [1:0] row, input logic [15:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = row;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  // One full run from a start pulse through the first idle cycle after done.
  // disturb: writes row0 during FEED and pulses start during FEED and DRAIN.
  task automatic run_check(input string name, input bit disturb);
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    check({name, " clr busy"}, busy, 1);
    check({name, " clr arr_clear"}, arr_clear, 1);
    check({name, " clr left"}, in_left, 0);
    check({name, " clr top"}, in_top, 0);
    for (int s = 0; s < 7; s++) begin
      tick();
      check($sformatf("%s step%0d left", name, s), in_left, exp_l[s]);
      check($sformatf("%s step%0d top", name, s), in_top, exp_t[s]);
      check($sformatf("%s step%0d clr", name, s), {busy, arr_clear, done}, 3'b100);
      if (disturb) begin
        if (s == 1) begin
          wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_data = 16'hFFFF;
        end
        if (s == 2) begin
          wr_en = 1'b0; start = 1'b1;
        end
        if (s == 3) start = 1'b0;
      end
    end
    for (int d = 0; d < 8; d++) begin
      tick();
      check($sformatf("%s drain%0d data", name, d), {in_left, in_top}, 0);
      check($sformatf("%s drain%0d flags", name, d), {busy, arr_clear, done}, 3'b100);
      if (disturb) begin
        if (d == 2) start = 1'b1;
        if (d == 3) start = 1'b0;
      end
    end
    tick();
    check({name, " done"}, {busy, done}, 2'b11);
    tick();
    check({name, " idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_data = '0; start = 1'b0;
    tick(); tick();
    check("reset outputs", {busy, done, arr_clear, in_left, in_top}, 0);
`ifdef SYSCTL_RUNCNT_EN
    check("reset run_count", run_count, 0);
`endif
    reset = 1'b0;
    tick();

    // Test 1: A[i][*]=i+1, B[*][j]=j+1.
    for (int r = 0; r < 4; r++) wr(1'b0, 2'(r), 16'h1111 * 16'(r + 1));
    for (int r = 0; r < 4; r++) wr(1'b1, 2'(r), 16'h4321);
    exp_l[0] = 16'h0001; exp_l[1] = 16'h0021; exp_l[2] = 16'h0321; exp_l[3] = 16'h4321;
    exp_l[4] = 16'h4320; exp_l[5] = 16'h4300; exp_l[6] = 16'h4000;
    exp_t = exp_l;
    run_check("t1", 1'b0);

    // Test 2: writes and starts while busy are ignored.
    run_check("t2", 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("t2 no rerun %0d", c), {busy, arr_clear}, 2'b00);
    end
    run_check("t2 old row0", 1'b0);

    // Test 3: write B row3 in the same cycle as start.
    wr_en = 1'b1; wr_sel = 1'b1; wr_row = 2'd3; wr_data = 16'h9999;
    exp_t[3] = 16'h4329; exp_t[4] = 16'h4390; exp_t[5] = 16'h4900; exp_t[6] = 16'h9000;
    run_check("t3", 1'b0);

    // Test 5: back-to-back runs, start in the idle cycle right after done.
    run_check("t5a", 1'b0);
    run_check("t5b", 1'b0);
`ifdef SYSCTL_RUNCNT_EN
    check("run_count after 6", run_count, 6);
`endif

    // Test 4: reset at FEED step 4 aborts and clears buffers.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 5; s++) tick();
    check("t4 step4 left", in_left, 16'h4320);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4 abort outputs", {busy, done, arr_clear, in_left, in_top}, 0);
`ifdef SYSCTL_RUNCNT_EN
    check("t4 run_count reset", run_count, 0);
`endif
    done_seen = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (done || busy) done_seen++;
    end
    check("t4 no done after abort", done_seen, 0);
    for (int s = 0; s < 7; s++) begin
      exp_l[s] = '0;
      exp_t[s] = '0;
    end
    run_check("t4 zero bufs", 1'b0);
`ifdef SYSCTL_RUNCNT_EN
    check("run_count after fresh run", run_count, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
